// File: rtl/uart_pkg.sv
`default_nettype none
// uart_pkg -- FSM state encodings and bit-timing helper shared by the UART TX/RX paths.
// Rev 1.0
package uart_pkg;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] START = 2'b01;
  localparam logic [1:0] DATA  = 2'b10;
  localparam logic [1:0] STOP  = 2'b11;

  function automatic int cycle_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// uart_tx_fifo -- byte FIFO in front of the UART serialiser; head is visible combinationally.
// Rev 1.0
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers are exactly log2(DEPTH) bits so they wrap without explicit compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// uart_tx -- 8N1 UART transmitter: buffered valid/ready byte input, LSB-first, idle-high line.
// Rev 1.0
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 27000000,
  parameter int BAUD_RATE  = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       valid,
  output logic       ready,
  output logic       tx,
  output logic       busy
);

  localparam int          CPB      = cycle_per_bit(CLK_FREQ, BAUD_RATE);
  localparam logic [15:0] BIT_LAST = 16'(CPB - 1);
  localparam int          CW       = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]    state;
  logic [15:0]   cycle_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic          bit_end;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_pop;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (valid),
    .din   (data_in),
    .full  (fifo_full),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bit_end  = (cycle_cnt == BIT_LAST);
  // Pop from IDLE, or at the end of STOP so the next start bit follows with no gap.
  assign fifo_pop = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_end));
  assign ready    = !fifo_full;
  assign busy     = (state != IDLE) || (fifo_count != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cycle_cnt <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      tx        <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (!fifo_empty) begin
            shift_reg <= fifo_dout;
            tx        <= 1'b0;
            cycle_cnt <= '0;
            state     <= START;
          end
        end
        START: begin
          if (bit_end) begin
            tx        <= shift_reg[0];
            bit_cnt   <= '0;
            cycle_cnt <= '0;
            state     <= DATA;
          end else begin
            cycle_cnt <= cycle_cnt + 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cycle_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              shift_reg <= {1'b0, shift_reg[7:1]};
              tx        <= shift_reg[1];
              bit_cnt   <= bit_cnt + 3'd1;
            end
          end else begin
            cycle_cnt <= cycle_cnt + 16'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            cycle_cnt <= '0;
            if (!fifo_empty) begin
              shift_reg <= fifo_dout;
              tx        <= 1'b0;
              state     <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            cycle_cnt <= cycle_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// tb_uart_tx -- randomized scoreboard bench for uart_tx at 16 clocks per bit.
// Rev 1.0
module tb_uart_tx;

  localparam int CPB   = 16;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       ready;
  logic       tx;
  logic       busy;

  uart_tx #(
    .CLK_FREQ   (16),
    .BAUD_RATE  (1),
    .FIFO_DEPTH (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .data_in (data_in),
    .valid   (valid),
    .ready   (ready),
    .tx      (tx),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         total = 0;
  int         bad = 0;
  logic [7:0] expq[$];
  int         starts[$];
  int         n_frames = 0;
  int         last_acc = 0;
  bit         saw_not_ready = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: capture whole frames from the line and compare against the scoreboard.
  initial begin : monitor
    logic       line [FRAME];
    bit         aborted;
    logic [7:0] eb;
    logic [7:0] got;
    logic [9:0] fr;
    int         errs;
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        starts.push_back(cyc);
        aborted = 0;
        line[0] = tx;
        for (int i = 1; i < FRAME; i++) begin
          @(negedge clk);
          if (rst) begin
            aborted = 1;
            break;
          end
          line[i] = tx;
        end
        if (!aborted) begin
          n_frames++;
          chk("frame_expected", int'(expq.size() > 0), 1);
          if (expq.size() > 0) begin
            eb   = expq.pop_front();
            fr   = {1'b1, eb, 1'b0};
            errs = 0;
            got  = 8'h00;
            for (int i = 0; i < FRAME; i++)
              if (line[i] !== fr[i / CPB]) errs++;
            for (int b = 0; b < 8; b++)
              got[b] = line[(b + 1) * CPB + CPB / 2];
            chk("frame_byte", int'(got), int'(eb));
            chk("frame_bits", errs, 0);
          end
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic push(input logic [7:0] b, input bit hold);
    bit acc;
    acc     = 0;
    data_in = b;
    valid   = 1'b1;
    for (int i = 0; i < 4000 && !acc; i++) begin
      if (!ready) saw_not_ready = 1;
      acc = ready;
      @(posedge clk);
      if (acc) expq.push_back(b);
      @(negedge clk);
    end
    last_acc = cyc;
    chk("push_accepted", int'(acc), 1);
    if (!hold) valid = 1'b0;
  endtask

  task automatic wait_drain();
    int i;
    i = 0;
    while ((expq.size() != 0 || busy) && i < 20000) begin
      @(negedge clk);
      i++;
    end
    chk("drain", int'(expq.size() == 0 && !busy), 1);
  endtask

  task automatic idle_check(input string tag, input int n);
    int etx, eb, er;
    etx = 0; eb = 0; er = 0;
    repeat (n) begin
      @(negedge clk);
      if (tx !== 1'b1)    etx++;
      if (busy !== 1'b0)  eb++;
      if (ready !== 1'b1) er++;
    end
    chk({tag, "_tx_high"}, etx, 0);
    chk({tag, "_busy_low"}, eb, 0);
    chk({tag, "_ready_high"}, er, 0);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  initial begin
    int a, n, s, t, nf, ns;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle_check("reset_idle", 100);

    // Single byte: start latency and busy fall time.
    n = starts.size();
    push(8'h55, 0);
    a = last_acc;
    t = 0;
    while (busy && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("t1_started", int'(starts.size() > n), 1);
    if (starts.size() > n) chk("t1_start_latency", starts[n] - a, 1);
    chk("t1_busy_fall", cyc - a, FRAME + 1);

    // Back-to-back frames are contiguous.
    n = starts.size();
    push(8'hA3, 1);
    push(8'h0F, 0);
    wait_drain();
    chk("t2_two_frames", starts.size() - n, 2);
    if (starts.size() >= n + 2) chk("t2_gap", starts[n + 1] - starts[n], FRAME);

    // FIFO full: held valid waits for a pop.
    n = starts.size();
    saw_not_ready = 0;
    for (int b = 1; b <= 6; b++) push(8'(b), (b != 6));
    chk("t3_ready_dropped", int'(saw_not_ready), 1);
    if (starts.size() > n) chk("t3_held_accept", last_acc - starts[n], FRAME + 1);
    wait_drain();
    chk("t3_frames", starts.size() - n, 6);

    // Push lands on the same edge as the STOP->START pop.
    n = starts.size();
    push(8'hB0, 1);
    push(8'hB1, 1);
    push(8'hB2, 1);
    push(8'hB3, 0);
    s = (starts.size() > n) ? starts[n] : cyc;
    wait_until(s + FRAME - 1);
    push(8'hC4, 0);
    chk("t4_push_on_pop", last_acc - s, FRAME);
    chk("t4_ready_after", int'(ready), 1);
    push(8'hC5, 0);
    chk("t4_full_after", int'(ready), 0);
    wait_drain();

    // Reset during data bit 3 with bytes queued.
    n = starts.size();
    push(8'hFF, 1);
    push(8'h11, 1);
    push(8'h22, 0);
    s = (starts.size() > n) ? starts[n] : cyc;
    wait_until(s + 4 * CPB + 5);
    #2 rst = 1'b1;
    #1;
    chk("t5_tx_on_reset", int'(tx), 1);
    chk("t5_busy_on_reset", int'(busy), 0);
    chk("t5_ready_on_reset", int'(ready), 1);
    expq.delete();
    nf = n_frames;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    ns = starts.size();
    idle_check("t5_idle", 100);
    chk("t5_no_frames", starts.size() - ns, 0);
    @(negedge clk);
    push(8'h81, 0);
    wait_drain();
    chk("t5_frames_after", n_frames - nf, 1);

    // Randomized traffic with occasional long gaps.
    repeat (24) begin
      t = $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) t += 200;
      repeat (t) @(negedge clk);
      push(8'($urandom), 0);
    end
    wait_drain();
    chk("queue_empty", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
